fib_seq_gen: RTL and testbench

FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

---
 rtl/fib_seq_gen_if.sv | 30 +++
 rtl/fib_seq_gen.sv | 149 ++++++++++++++
 tb/tb_fib_seq_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fib_seq_gen_if.sv
// Request/stream bundle for fib_seq_gen: start request with seeds and term
// count, the output term stream with its ready/valid handshake, and status flags.
interface fib_seq_gen_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 8
) ();

   logic             start;
   logic [WIDTH-1:0] seed0;
   logic [WIDTH-1:0] seed1;
   logic [IDX_W-1:0] n_terms;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [IDX_W-1:0] out_idx;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, seed0, seed1, n_terms, out_ready,
      input  out_valid, out_data, out_idx, busy, done, ovf
   );

   modport slave (
      input  start, seed0, seed1, n_terms, out_ready,
      output out_valid, out_data, out_idx, busy, done, ovf
   );

endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci-style sequence generator streaming terms over a ready/valid handshake.
// Optional overflow abort is compiled in with the FIB_OVF_DETECT_EN macro.
module fib_seq_gen #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 8
) (
   input logic            clk,
   input logic            rst,
   fib_seq_gen_if.slave   bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] limit_q, limit_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] sum;
   logic             term_bad;
   logic             start_accept;
   logic             handshake;
   logic             abort;
   logic             valid;

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      limit_d      = limit_q;
      done_d       = 1'b0;
      start_accept = 1'b0;
      handshake    = 1'b0;
      abort        = 1'b0;
      valid        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.n_terms != '0) begin
                  start_accept = 1'b1;
                  a_d          = bus.seed0;
                  b_d          = bus.seed1;
                  cnt_d        = '0;
                  limit_d      = bus.n_terms;
                  state_d      = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            // A poisoned term is never presented; the run ends instead.
            if (term_bad) begin
               abort   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               valid     = 1'b1;
               handshake = bus.out_ready;
               if (handshake) begin
                  a_d   = b_q;
                  b_d   = sum;
                  cnt_d = cnt_q + IDX_W'(1);
                  if (cnt_q == limit_q - IDX_W'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         limit_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
         done_q  <= done_d;
      end
   end

`ifdef FIB_OVF_DETECT_EN
   logic a_bad_q, a_bad_d;
   logic b_bad_q, b_bad_d;
   logic ovf_q, ovf_d;
   logic carry;

   assign {carry, sum} = {1'b0, a_q} + {1'b0, b_q};
   assign term_bad     = a_bad_q;

   // Bad bits travel with a/b so a wrapped sum is caught when it reaches the output.
   always_comb begin
      a_bad_d = a_bad_q;
      b_bad_d = b_bad_q;
      ovf_d   = ovf_q;
      if (start_accept) begin
         a_bad_d = 1'b0;
         b_bad_d = 1'b0;
         ovf_d   = 1'b0;
      end
      if (handshake) begin
         a_bad_d = b_bad_q;
         b_bad_d = carry | a_bad_q | b_bad_q;
      end
      if (abort) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_bad_q <= 1'b0;
         b_bad_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_bad_q <= a_bad_d;
         b_bad_q <= b_bad_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign sum      = a_q + b_q;
   assign term_bad = 1'b0;
   assign bus.ovf  = 1'b0;
`endif

   assign bus.out_valid = valid;
   assign bus.out_data  = a_q;
   assign bus.out_idx   = cnt_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen (WIDTH=4 so wrap behaviour is reachable).
// Overflow expectations follow the FIB_OVF_DETECT_EN macro.
module tb_fib_seq_gen;

   localparam int WIDTH = 4;
   localparam int IDX_W = 8;

   logic clk;
   logic rst;
   int   compareCount;
   int   mismatchCount;

   fib_seq_gen_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

   fib_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                                input logic [IDX_W-1:0] n, input logic rdy);
      bus.start     = st;
      bus.seed0     = s0;
      bus.seed1     = s1;
      bus.n_terms   = n;
      bus.out_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] fibA [10];
      logic [WIDTH-1:0] fibB [5];
      logic [3:0]       readyPat;
      int               k;
      int               count;
      int               lastIdx;

      fibA = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5, 4'd2};
      fibB = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd7};
      readyPat = 4'b1001;
      compareCount  = 0;
      mismatchCount = 0;

      // Reset state
      rst = 1'b1;
      applyStimulus(1'b1, 4'd3, 4'd4, 8'd5, 1'b1);
      step();
      step();
      checkOutput("rst_valid", 32'(bus.out_valid), 0);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_done", 32'(bus.done), 0);
      checkOutput("rst_ovf", 32'(bus.ovf), 0);
      rst = 1'b0;
      applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
      step();

      $display("[TB] basic 8-term run");
      applyStimulus(1'b1, 4'd0, 4'd1, 8'd8, 1'b1);
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput("b8_valid", 32'(bus.out_valid), 1);
         checkOutput("b8_data", 32'(bus.out_data), 32'(fibA[i]));
         checkOutput("b8_idx", 32'(bus.out_idx), 32'(i));
         checkOutput("b8_done_low", 32'(bus.done), 0);
         step();
      end
      checkOutput("b8_done", 32'(bus.done), 1);
      checkOutput("b8_valid_end", 32'(bus.out_valid), 0);
      checkOutput("b8_busy_end", 32'(bus.busy), 0);
      checkOutput("b8_ovf", 32'(bus.ovf), 0);
      step();
      checkOutput("b8_done_pulse", 32'(bus.done), 0);

      $display("[TB] 10-term run through wrap");
      applyStimulus(1'b1, 4'd0, 4'd1, 8'd10, 1'b1);
      step();
      bus.start = 1'b0;
`ifdef FIB_OVF_DETECT_EN
      for (int i = 0; i < 8; i++) begin
         checkOutput("w10_valid", 32'(bus.out_valid), 1);
         checkOutput("w10_data", 32'(bus.out_data), 32'(fibA[i]));
         step();
      end
      checkOutput("w10_gap_valid", 32'(bus.out_valid), 0);
      checkOutput("w10_gap_done", 32'(bus.done), 0);
      step();
      checkOutput("w10_done", 32'(bus.done), 1);
      checkOutput("w10_ovf", 32'(bus.ovf), 1);
      for (int i = 0; i < 5; i++) step();
      checkOutput("w10_ovf_hold", 32'(bus.ovf), 1);
      checkOutput("w10_done_low", 32'(bus.done), 0);
`else
      for (int i = 0; i < 10; i++) begin
         checkOutput("w10_valid", 32'(bus.out_valid), 1);
         checkOutput("w10_data", 32'(bus.out_data), 32'(fibA[i]));
         checkOutput("w10_idx", 32'(bus.out_idx), 32'(i));
         checkOutput("w10_ovf_run", 32'(bus.ovf), 0);
         step();
      end
      checkOutput("w10_done", 32'(bus.done), 1);
      checkOutput("w10_ovf", 32'(bus.ovf), 0);
      step();
`endif

      $display("[TB] stalled run with mid-run start");
      applyStimulus(1'b1, 4'd2, 4'd1, 8'd5, 1'b1);
      step();
      bus.start = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
         checkOutput("st_valid", 32'(bus.out_valid), 1);
         checkOutput("st_data", 32'(bus.out_data), 32'(fibB[k]));
         checkOutput("st_idx", 32'(bus.out_idx), 32'(k));
         if (cyc == 2) applyStimulus(1'b1, 4'd9, 4'd9, 8'd3, readyPat[cyc % 4]);
         else begin
            bus.start     = 1'b0;
            bus.out_ready = readyPat[cyc % 4];
         end
         step();
         if (readyPat[cyc % 4]) k++;
      end
      checkOutput("st_terms", 32'(k), 5);
      checkOutput("st_done", 32'(bus.done), 1);
      checkOutput("st_busy", 32'(bus.busy), 0);
      applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
      step();
      checkOutput("st_idle_busy", 32'(bus.busy), 0);

      $display("[TB] zero-length request");
      applyStimulus(1'b1, 4'd1, 4'd1, 8'd0, 1'b1);
      step();
      checkOutput("z_done", 32'(bus.done), 1);
      checkOutput("z_valid", 32'(bus.out_valid), 0);
      checkOutput("z_busy", 32'(bus.busy), 0);
      bus.start = 1'b0;
      step();
      checkOutput("z_done_pulse", 32'(bus.done), 0);
      checkOutput("z_valid2", 32'(bus.out_valid), 0);

      $display("[TB] reset during run");
      applyStimulus(1'b1, 4'd0, 4'd1, 8'd8, 1'b1);
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checkOutput("r_idx4", 32'(bus.out_idx), 4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("r_valid", 32'(bus.out_valid), 0);
      checkOutput("r_busy", 32'(bus.busy), 0);
      checkOutput("r_done", 32'(bus.done), 0);
      step();
      checkOutput("r_done2", 32'(bus.done), 0);
      applyStimulus(1'b1, 4'd0, 4'd1, 8'd3, 1'b1);
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("r_rs_idx", 32'(bus.out_idx), 32'(i));
         checkOutput("r_rs_data", 32'(bus.out_data), 32'(fibA[i]));
         step();
      end
      checkOutput("r_rs_done", 32'(bus.done), 1);
      step();

      $display("[TB] maximum-length request");
      applyStimulus(1'b1, 4'd0, 4'd0, 8'd255, 1'b1);
      step();
      bus.start = 1'b0;
      count   = 0;
      lastIdx = -1;
      for (int cyc = 0; cyc < 300 && bus.out_valid === 1'b1; cyc++) begin
         lastIdx = int'(bus.out_idx);
         count++;
         step();
      end
      checkOutput("max_count", 32'(count), 255);
      checkOutput("max_last_idx", 32'(lastIdx), 254);
      checkOutput("max_done", 32'(bus.done), 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
